// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the divide unit
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;
  typedef enum logic [1:0] {IDLE, DIVZ, DIVON, DONE} div_state_e;
endpackage

// File: rtl/mips_div_unit_if.sv
// mips_div_unit_if: divstart/divready handshake between issue logic and divider
interface mips_div_unit_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);
  logic start;
  logic signed_div;
  logic annul;
  logic ready;
  logic busy;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic [2*WIDTH-1:0] result;
  modport master(output start, signed_div, opdata1, opdata2, annul, input result, ready, busy);
  modport slave(input start, signed_div, opdata1, opdata2, annul, output result, ready, busy);
endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: operand magnitudes before the divide, quotient/remainder sign restore after it
module div_sign_fix
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH) (
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_mag1,
  output logic [WIDTH-1:0] o_mag2,
  output logic             o_neg_q,
  output logic             o_neg_r,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_rem,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);
  logic w_neg2;
  assign w_neg2  = i_signed & i_op2[WIDTH-1];
  assign o_neg_r = i_signed & i_op1[WIDTH-1];
  assign o_neg_q = o_neg_r ^ w_neg2;
  // most-negative dividend negates to itself, which is its correct unsigned magnitude
  assign o_mag1  = o_neg_r ? -i_op1 : i_op1;
  assign o_mag2  = w_neg2 ? -i_op2 : i_op2;
  assign o_quo   = i_neg_q ? -i_quo : i_quo;
  assign o_rem   = i_neg_r ? -i_rem : i_rem;
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: radix-2 restoring DIV/DIVU unit; define DIV_EARLY_OUT_EN for the |dividend|<|divisor| shortcut
module mips_div_unit
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic rst,
  mips_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  div_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_hold, r_fill;
  logic [2*WIDTH-1:0] r_result;
  logic r_neg_q, r_neg_r;
  logic [WIDTH-1:0] w_mag1, w_mag2, w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic [WIDTH:0] w_shift, w_diff;
  logic w_neg_q, w_neg_r, w_bit, w_go, w_divz, w_early, w_last;
  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_signed(bus.signed_div), .i_op1(bus.opdata1), .i_op2(bus.opdata2),
    .o_mag1(w_mag1), .o_mag2(w_mag2), .o_neg_q(w_neg_q), .o_neg_r(w_neg_r),
    .i_neg_q(r_neg_q), .i_neg_r(r_neg_r), .i_quo(w_quo), .i_rem(w_rem),
    .o_quo(w_quo_fix), .o_rem(w_rem_fix)
  );
  // a new divide may start from IDLE or straight out of DONE (back-to-back); annul blocks it
  assign w_go   = bus.start & ~bus.annul & (r_state == IDLE || r_state == DONE);
  assign w_divz = bus.opdata2 == '0;
  assign w_last = r_cnt == LAST;
`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_mag1 < w_mag2;
`else
  assign w_early = 1'b0;
`endif
  // one restoring step: shift in the next dividend bit, subtract divisor if it fits
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_bit   = ~w_diff[WIDTH];
  assign w_rem   = w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo   = {r_dvd[WIDTH-2:0], w_bit};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state; the short paths (zero divisor, early out) share the one-cycle DIVZ wait
  always_comb begin
    w_next = r_state;
    w_next = bus.annul ? IDLE :
             w_go ? ((w_divz || w_early) ? DIVZ : DIVON) :
             (r_state == DIVON) ? (w_last ? DONE : DIVON) :
             (r_state == DIVZ) ? DONE : IDLE;
  end
  // operand capture at start, then one quotient bit per cycle; dividend register becomes the quotient
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_hold  <= '0;
      r_fill  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_go) begin
      r_cnt   <= '0;
      r_dvd   <= w_mag1;
      r_dvs   <= w_mag2;
      r_rem   <= '0;
      r_hold  <= bus.opdata1;
      r_fill  <= w_divz ? '1 : '0;
      r_neg_q <= w_neg_q;
      r_neg_r <= w_neg_r;
    end else if (r_state == DIVON && !bus.annul) begin
      r_cnt   <= r_cnt + 1'b1;
      r_dvd   <= w_quo;
      r_rem   <= w_rem;
    end
  // result only changes on entry to DONE, so annul never disturbs it
  always_ff @(posedge clk or posedge rst)
    if (rst) r_result <= '0;
    else if (!bus.annul && r_state == DIVON && w_last) r_result <= {w_rem_fix, w_quo_fix};
    else if (!bus.annul && r_state == DIVZ) r_result <= {r_hold, r_fill};
  assign bus.result = r_result;
  assign bus.ready  = r_state == DONE;
  assign bus.busy   = r_state != IDLE;
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: scoreboard bench for mips_div_unit with randomized and directed divides
module tb_mips_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] last_res = '0;
  typedef struct { logic [63:0] res; int at; } exp_t;
  exp_t sb[$];
  mips_div_unit_if bus();
  mips_div_unit dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (ma < mb) return 1;
    end
`endif
    return 32;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    bus.start = 1'b1;
    bus.signed_div = s;
    bus.opdata1 = a;
    bus.opdata2 = b;
    e.res = model(s, a, b);
    e.at = cyc + 1 + lat(s, a, b);
    sb.push_back(e);
    last_res = e.res;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 100);
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ready for %h / %h after %0d cycles", a, b, n);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic s;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.annul = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_result", bus.result, 64'h0);
    chk("rst_ready", 64'(bus.ready), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'd2);
    chk("udiv_7_2", bus.result, 64'h00000001_00000003);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", 64'(bus.ready), 64'h0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("sdiv_m7_2", bus.result, 64'hFFFFFFFF_FFFFFFFD);
    bus.start = 1'b0;
    @(negedge clk);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    chk("sdiv_7_m2", bus.result, 64'h00000001_FFFFFFFD);
    bus.start = 1'b0;
    @(negedge clk);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("sdiv_minneg", bus.result, 64'h00000000_80000000);
    bus.start = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("udiv_minneg", bus.result, 64'h80000000_00000000);
    bus.start = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h1234, 32'd0);
    chk("div_zero", bus.result, 64'h00001234_FFFFFFFF);
    bus.start = 1'b0;
    @(negedge clk);
    // annul part-way through: no pulse, result kept
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    chk("annul_busy", 64'(bus.busy), 64'h0);
    chk("annul_ready", 64'(bus.ready), 64'h0);
    chk("annul_result", bus.result, last_res);
    repeat (40) @(negedge clk);
    // asynchronous reset mid-divide
    bus.start = 1'b1;
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_result", bus.result, 64'h0);
    chk("arst_ready", 64'(bus.ready), 64'h0);
    chk("arst_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    // back-to-back with operands changed in the DONE cycle
    issue(1'b0, 32'd100, 32'd7);
    chk("b2b_first", bus.result, 64'h00000002_0000000E);
    issue(1'b0, 32'd9, 32'd3);
    chk("b2b_second", bus.result, 64'h00000000_00000003);
    bus.start = 1'b0;
    @(negedge clk);
`ifdef DIV_EARLY_OUT_EN
    issue(1'b0, 32'd3, 32'd9);
    chk("early_out", bus.result, 64'h00000003_00000000);
    bus.start = 1'b0;
    @(negedge clk);
`endif
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: begin
          a = $urandom_range(0, 20);
          b = $urandom_range(1, 40);
        end
      endcase
      issue(s, a, b);
      if ($urandom_range(0, 1) == 1) begin
        bus.start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
